count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor.sv | 133 +++++++++++++
 tb/tb_count_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
// Deglitching monitor for a 3-bit asynchronous ripple down counter: synchronises,
// filters ripple transients, checks the decrement sequence and drives a 7-segment display.
module count_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CYC  = 3,
    parameter int unsigned WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        count_in,
    input  logic              clear,
    output logic [2:0]        value,
    output logic [6:0]        seg,
    output logic              step,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    localparam logic [3:0] StabMax = 4'(STABLE_CYC - 1);

    state_e                      state_q;
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [SYNC_STAGES-1:0]      vld_q;
    logic [2:0]                  s;
    logic [2:0]                  s_prev_q;
    logic                        s_prev_vld_q;
    logic [3:0]                  stab_q;
    logic [3:0]                  stab_d;
    logic                        s_vld;
    logic                        changed;
    logic                        accept;

    function automatic logic [6:0] seg_of(input logic [2:0] v);
        logic [6:0] r;
        unique case (v)
            3'd0:    r = 7'b0111111;
            3'd1:    r = 7'b0000110;
            3'd2:    r = 7'b1011011;
            3'd3:    r = 7'b1001111;
            3'd4:    r = 7'b1100110;
            3'd5:    r = 7'b1101101;
            3'd6:    r = 7'b1111101;
            default: r = 7'b0000111;
        endcase
        return r;
    endfunction

    assign s     = sync_q[SYNC_STAGES-1];
    assign s_vld = vld_q[SYNC_STAGES-1];

    // Zeros left in the synchroniser by reset must not look like a stable sample,
    // so a valid bit travels alongside and the first valid sample counts as a change.
    always_comb begin
        changed = !s_prev_vld_q || (s != s_prev_q);
        if (!s_vld || changed) begin
            stab_d = 4'd0;
        end else if (stab_q == StabMax) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + 4'd1;
        end
        accept = s_vld && (stab_d == StabMax) && (changed || (stab_q != StabMax));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            vld_q        <= '0;
            s_prev_q     <= 3'd0;
            s_prev_vld_q <= 1'b0;
            stab_q       <= 4'd0;
            state_q      <= StIdle;
            value        <= 3'd0;
            seg          <= 7'd0;
            step         <= 1'b0;
            wrap         <= 1'b0;
            wrap_cnt     <= '0;
            err          <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], count_in};
            vld_q        <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            s_prev_q     <= s;
            s_prev_vld_q <= s_vld;
            step         <= 1'b0;
            wrap         <= 1'b0;
            if (clear) begin
                state_q  <= StIdle;
                stab_q   <= 4'd0;
                wrap_cnt <= '0;
                err      <= 1'b0;
            end else begin
                stab_q <= stab_d;
                if (accept) begin
                    unique case (state_q)
                        StIdle: begin
                            value   <= s;
                            seg     <= seg_of(s);
                            state_q <= StTrack;
                        end
                        StTrack: begin
                            if (s == value) begin
                                // Same count re-accepted: nothing to do.
                            end else if (s == value - 3'd1) begin
                                value <= s;
                                seg   <= seg_of(s);
                                step  <= 1'b1;
                                if (value == 3'd0) begin
                                    wrap <= 1'b1;
                                    if (wrap_cnt != '1) begin
                                        wrap_cnt <= wrap_cnt + WRAP_W'(1);
                                    end
                                end
                            end else begin
                                value   <= s;
                                seg     <= seg_of(s);
                                err     <= 1'b1;
                                state_q <= StFault;
                            end
                        end
                        default: begin
                            value <= s;
                            seg   <= seg_of(s);
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor; a second instance with WRAP_W=2 checks saturation.
module tb_count_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count_in;
    logic       clear;
    logic [2:0] value,  value2;
    logic [6:0] seg,    seg2;
    logic       step,   step2;
    logic       wrap,   wrap2;
    logic [7:0] wrap_cnt;
    logic [1:0] wrap_cnt2;
    logic       err,    err2;

    int checks = 0;
    int errors = 0;

    count_monitor dut (
        .clk(clk), .rst(rst), .count_in(count_in), .clear(clear),
        .value(value), .seg(seg), .step(step), .wrap(wrap),
        .wrap_cnt(wrap_cnt), .err(err)
    );

    count_monitor #(.WRAP_W(2)) dut2 (
        .clk(clk), .rst(rst), .count_in(count_in), .clear(clear),
        .value(value2), .seg(seg2), .step(step2), .wrap(wrap2),
        .wrap_cnt(wrap_cnt2), .err(err2)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold v for n cycles; count step/wrap pulses and any step not on the 5th cycle.
    task automatic hold(input logic [2:0] v, input int n, output int st, output int wr,
                        output int mis);
        st = 0; wr = 0; mis = 0;
        count_in = v;
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (step) begin
                st++;
                if (i != 5) mis++;
            end
            if (wrap) wr++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; count_in = 3'd0;
        tick(3);
        if (value !== 3'd0) begin $display("FAIL reset_value: got %0d want 0", value); errors++; end
        checks++;
        if (seg !== 7'd0) begin $display("FAIL reset_seg: got %b want 0000000", seg); errors++; end
        checks++;
        if ({step, wrap, err} !== 3'b000) begin
            $display("FAIL reset_flags: got %b want 000", {step, wrap, err}); errors++;
        end
        checks++;
        if (wrap_cnt !== 8'd0) begin $display("FAIL reset_wrap_cnt: got %0d want 0", wrap_cnt); errors++; end
        checks++;
    endtask

    task automatic test_first_accept();
        count_in = 3'd5;
        rst = 1'b0;
        tick(4);
        if (value !== 3'd0) begin $display("FAIL first_early: got %0d want 0", value); errors++; end
        checks++;
        tick(1);
        if (value !== 3'd5) begin $display("FAIL first_value: got %0d want 5", value); errors++; end
        checks++;
        if (seg !== 7'b1101101) begin $display("FAIL first_seg: got %b want 1101101", seg); errors++; end
        checks++;
        if (step !== 1'b0) begin $display("FAIL first_step: got %b want 0", step); errors++; end
        checks++;
        tick(1);
    endtask

    task automatic test_sequence();
        int st, wr, mis, tst = 0, twr = 0, tmis = 0;
        logic [2:0] seq [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        foreach (seq[k]) begin
            hold(seq[k], 6, st, wr, mis);
            tst += st; twr += wr; tmis += mis;
        end
        if (tst != 6) begin $display("FAIL seq_steps: got %0d want 6", tst); errors++; end
        checks++;
        if (tmis != 0) begin $display("FAIL seq_latency: got %0d misplaced want 0", tmis); errors++; end
        checks++;
        if (twr != 1) begin $display("FAIL seq_wraps: got %0d want 1", twr); errors++; end
        checks++;
        if (wrap_cnt !== 8'd1) begin $display("FAIL seq_wrap_cnt: got %0d want 1", wrap_cnt); errors++; end
        checks++;
        if (err !== 1'b0) begin $display("FAIL seq_err: got %b want 0", err); errors++; end
        checks++;
        if (seg !== 7'b0000111) begin $display("FAIL seq_seg: got %b want 0000111", seg); errors++; end
        checks++;
    endtask

    task automatic test_glitch();
        int st, wr, mis, tst = 0;
        hold(3'd6, 6, st, wr, mis);
        hold(3'd5, 6, st, wr, mis);
        hold(3'd4, 6, st, wr, mis);
        hold(3'd7, 2, st, wr, mis);
        tst += st;
        hold(3'd3, 8, st, wr, mis);
        tst += st;
        if (err !== 1'b0) begin $display("FAIL glitch_err: got %b want 0", err); errors++; end
        checks++;
        if (tst != 1) begin $display("FAIL glitch_steps: got %0d want 1", tst); errors++; end
        checks++;
        if (value !== 3'd3) begin $display("FAIL glitch_value: got %0d want 3", value); errors++; end
        checks++;
        if (seg !== 7'b1001111) begin $display("FAIL glitch_seg: got %b want 1001111", seg); errors++; end
        checks++;
    endtask

    task automatic test_fault();
        int st, wr, mis;
        logic [2:0] seq [5] = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
        foreach (seq[k]) hold(seq[k], 6, st, wr, mis);
        count_in = 3'd2;
        tick(4);
        if (err !== 1'b0) begin $display("FAIL fault_early: got %b want 0", err); errors++; end
        checks++;
        tick(1);
        if (err !== 1'b1) begin $display("FAIL fault_err: got %b want 1", err); errors++; end
        checks++;
        if (value !== 3'd2 || step !== 1'b0) begin
            $display("FAIL fault_value: got %0d/%b want 2/0", value, step); errors++;
        end
        checks++;
        tick(1);
        hold(3'd1, 6, st, wr, mis);
        if (st != 0 || value !== 3'd1) begin
            $display("FAIL fault_no_step: got steps %0d value %0d want 0/1", st, value); errors++;
        end
        checks++;
        hold(3'd2, 6, st, wr, mis);
        if (err !== 1'b1 || value !== 3'd2) begin
            $display("FAIL fault_sticky: got err %b value %0d want 1/2", err, value); errors++;
        end
        checks++;
        if (wrap_cnt !== 8'd2) begin $display("FAIL fault_wrap_cnt: got %0d want 2", wrap_cnt); errors++; end
        checks++;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        if (err !== 1'b0 || wrap_cnt !== 8'd0 || wrap_cnt2 !== 2'd0) begin
            $display("FAIL clear_stats: got err %b cnt %0d/%0d want 0/0/0", err, wrap_cnt, wrap_cnt2);
            errors++;
        end
        checks++;
        if (seg !== 7'b1011011 || value !== 3'd2) begin
            $display("FAIL clear_hold: got %b/%0d want 1011011/2", seg, value); errors++;
        end
        checks++;
        tick(4);
    endtask

    task automatic test_clear_accept();
        int st, wr, mis;
        hold(3'd1, 6, st, wr, mis);
        hold(3'd0, 6, st, wr, mis);
        if (st != 1) begin $display("FAIL rearm_step: got %0d want 1", st); errors++; end
        checks++;
        count_in = 3'd7;
        tick(4);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        if (step !== 1'b0 || wrap !== 1'b0 || value !== 3'd0) begin
            $display("FAIL clear_accept: got step %b wrap %b value %0d want 0/0/0", step, wrap, value);
            errors++;
        end
        checks++;
        hold(3'd7, 6, st, wr, mis);
        if (st != 0 || wr != 0 || wrap_cnt !== 8'd0 || value !== 3'd7) begin
            $display("FAIL clear_idle: got steps %0d wraps %0d cnt %0d value %0d want 0/0/0/7",
                     st, wr, wrap_cnt, value);
            errors++;
        end
        checks++;
    endtask

    task automatic test_rst_accept();
        int st, wr, mis;
        count_in = 3'd6;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        if (step !== 1'b0 || value !== 3'd0 || seg !== 7'd0) begin
            $display("FAIL rst_accept: got step %b value %0d seg %b want 0/0/0000000", step, value, seg);
            errors++;
        end
        checks++;
        hold(3'd3, 6, st, wr, mis);
        if (err !== 1'b0 || st != 0 || value !== 3'd3) begin
            $display("FAIL rst_idle: got err %b steps %0d value %0d want 0/0/3", err, st, value);
            errors++;
        end
        checks++;
    endtask

    task automatic test_wrap_sat();
        int st, wr, mis;
        logic [2:0] seq [8] = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
        for (int r = 0; r < 5; r++) begin
            foreach (seq[k]) hold(seq[k], 6, st, wr, mis);
        end
        if (wrap_cnt2 !== 2'd3) begin $display("FAIL wrap_sat: got %0d want 3", wrap_cnt2); errors++; end
        checks++;
        if (wrap_cnt !== 8'd5) begin $display("FAIL wrap_count: got %0d want 5", wrap_cnt); errors++; end
        checks++;
        if (err !== 1'b0 || err2 !== 1'b0) begin
            $display("FAIL wrap_err: got %b/%b want 0/0", err, err2); errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_sequence();
        test_glitch();
        test_fault();
        test_clear_accept();
        test_rst_accept();
        test_wrap_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
